modexp_47_ctrl: RTL and testbench

Sequential modular-exponentiation controller for the mod-47 arithmetic datapath. It computes result = base^exp mod 47 by left-to-right square-and-multiply. A single shared instance of the combinational mod-47 multiplier is issued one product per clock. The block sits between a requesting unit and that multiplier and owns the operand registers, the bit scheduling and the start/busy/done handshake.

---
 rtl/modexp47_pkg.sv | 18 +
 rtl/mult_mod_47_bits.sv | 15 +
 rtl/modexp_47_ctrl.sv | 113 +++++++++++
 tb/tb_modexp_47_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/modexp47_pkg.sv
// Shared constants, FSM encodings and base-reduction helper for the mod-47
// exponentiation controller.
package modexp47_pkg;

  localparam int MOD    = 47;
  localparam int DATA_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQR  = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Raw 6-bit inputs only exceed the modulus by at most 16, so one subtraction suffices.
  function automatic logic [DATA_W-1:0] reduce_base(input logic [DATA_W-1:0] b);
    return (b >= DATA_W'(MOD)) ? b - DATA_W'(MOD) : b;
  endfunction

endpackage

// File: rtl/mult_mod_47_bits.sv
// Combinational mod-47 multiplier; operands are expected to be already reduced.
module mult_mod_47_bits
  import modexp47_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;
  assign r    = DATA_W'(prod % (2*DATA_W)'(MOD));

endmodule

// File: rtl/modexp_47_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod 47
// with a single shared combinational multiplier.
module modexp_47_ctrl
  import modexp47_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W:1]   base,
  input  logic [EXP_W-1:0]  exp,
  output logic              busy,
  output logic              done,
  output logic [DATA_W:1]   result
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] mul_a, mul_b, mul_r;

  mult_mod_47_bits u_mult (
    .a (mul_a),
    .b (mul_b),
    .r (mul_r)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    mul_a    = '0;
    mul_b    = '0;
    // done/result are registered out of FIN so they never depend on start
    done_d   = (state_q == ST_FIN);
    result_d = (state_q == ST_FIN) ? acc_q : result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = reduce_base(base);
          exp_d   = exp;
          acc_d   = DATA_W'(1);
          idx_d   = IDX_TOP;
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        mul_a = acc_q;
        mul_b = acc_q;
        acc_d = mul_r;
        if (exp_q[idx_q]) begin
          state_d = ST_MUL;
        end else if (idx_q == '0) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_MUL: begin
        mul_a = acc_q;
        mul_b = base_q;
        acc_d = mul_r;
        if (idx_q == '0) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_SQR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= DATA_W'(1);
      base_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // busy also covers the done cycle, when the FSM is already back in IDLE
  assign busy   = (state_q != ST_IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_modexp_47_ctrl.sv
// Scoreboard bench for modexp_47_ctrl: each accepted request pushes its
// expected result and done cycle; the done monitor pops and compares.
module tb_modexp_47_ctrl;

  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [6:1]       base = '0;
  logic [EXP_W-1:0] exp_i = '0;
  logic             busy;
  logic             done;
  logic [6:1]       result;

  modexp_47_ctrl #(.EXP_W(EXP_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp    (exp_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  res;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [5:0] ref_pow(input logic [5:0] b, input int e);
    int r;
    int bb;
    r  = 1;
    bb = int'(b) % 47;
    for (int i = 0; i < e; i++) r = (r * bb) % 47;
    return 6'(r);
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%0d required no done", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL result cyc=%0d got=%0d required=%0d", cyc, result, mon_e.res);
        end
        checks++;
        if (cyc !== mon_e.at) begin
          errors++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  task automatic issue(input logic [5:0] b, input logic [EXP_W-1:0] e, output int unsigned k);
    wait_ready();
    start = 1'b1;
    base  = b;
    exp_i = e;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back('{res: ref_pow(b, int'(e)), at: k + EXP_W + $countones(e) + 1});
    start = 1'b0;
    base  = 6'($urandom);
    exp_i = EXP_W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b required=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b required=0", done); end
    if (result !== 6'd0) begin errors++; $display("FAIL reset_result got=%0d required=0", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int unsigned k;
    int bc = 0;
    int n = 0;
    issue(6'd3, 8'd5, k);
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bc++;
      else break;
    end
    checks++;
    if (bc != 12) begin errors++; $display("FAIL basic_busy_len got=%0d required=12", bc); end
    wait_drain();
    checks++;
    if (result !== 6'd8) begin errors++; $display("FAIL basic_held_result got=%0d required=8", result); end
  endtask

  task automatic test_fermat();
    int unsigned k;
    issue(6'd2, 8'd46, k);
    issue(6'd5, 8'd0, k);
    wait_drain();
    checks++;
    if (result !== 6'd1) begin errors++; $display("FAIL exp0_result got=%0d required=1", result); end
  endtask

  task automatic test_reduce();
    int unsigned k;
    issue(6'd50, 8'd2, k);
    issue(6'd0, 8'd7, k);
    issue(6'd0, 8'd0, k);
    issue(6'd47, 8'd1, k);
    issue(6'd63, 8'd3, k);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int unsigned k;
    int dc = 0;
    int bl = 0;
    wait_ready();
    start = 1'b1;
    base  = 6'd46;
    exp_i = 8'd255;
    @(posedge clk);
    #1;
    k = cyc;
    for (int i = 0; i < 3; i++) sb.push_back('{res: 6'd46, at: k + 17 + 18 * i});
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
      if (busy !== 1'b1) bl++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    checks += 2;
    if (dc != 2) begin errors++; $display("FAIL b2b_done_count got=%0d required=2", dc); end
    if (bl != 0) begin errors++; $display("FAIL b2b_busy_gap got=%0d required=0", bl); end
  endtask

  task automatic test_reset_mid();
    int unsigned k;
    issue(6'd3, 8'hFF, k);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%0b required=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%0b required=0", done); end
    if (result !== 6'd0) begin errors++; $display("FAIL mid_reset_result got=%0d required=0", result); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%0b required=0", busy); end
    issue(6'd3, 8'd5, k);
    wait_drain();
  endtask

  task automatic test_random();
    int unsigned k;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), k);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fermat();
    test_reduce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d required=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
